// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit_if
//  Purpose  : Request / HI-LO access bundle between the execute stage and
//             the md_unit multiply/divide block.
//  Signals  : start, op[2:0], a, b     - operation request and operands
//             hi_we, lo_we, wdata      - mthi / mtlo writes
//             busy, done, hi, lo       - status and accumulator registers
//  Modports : master (execute stage side), slave (md_unit side)
//  Revision : 1.0 - initial release
// ============================================================================
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : Iterative multiply / divide unit with HI/LO registers.
//             Multiply family commits after MUL_LAT cycles; divide uses a
//             bit-serial restoring divider and commits after WIDTH+2 cycles.
//  Ports    : clk   - rising-edge clock
//             reset - synchronous, active-high
//             bus   - md_unit_if.slave (request, mthi/mtlo, busy/done, hi/lo)
//  Options  : MD_MAC_EN - when defined, ops 4..7 (MADD(U)/MSUB(U)) are
//             accepted and accumulate into {HI,LO}; otherwise those op codes
//             are ignored and no accumulator adder is built.
//  Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  wire logic  clk,
  input  wire logic  reset,
  md_unit_if.slave   bus
);

  localparam int c_CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL      = 3'd1,
    S_DIV_LOAD = 3'd2,
    S_DIV_ITER = 3'd3,
    S_DIV_FIX  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // Divider state: r_quo starts as the dividend magnitude and is shifted
  // left while quotient bits enter at the bottom.
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_dz;

  logic               w_accept;
  logic               w_mul_commit;
  logic               w_div_commit;
  logic               w_is_div;
  logic               w_op_ok;

  assign w_is_div = (bus.op[2:1] == 2'b01);

`ifdef MD_MAC_EN
  logic r_acc_en;
  logic r_acc_sub;
  assign w_op_ok = 1'b1;
`else
  assign w_op_ok = ~bus.op[2];
`endif

  // --------------------------------------------------------------------------
  // Multiply datapath: sign/zero-extend to 2*WIDTH so a single unsigned
  // multiply truncated to 2*WIDTH bits yields the correct signed product.
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;

  assign w_ext_a = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
  assign w_ext_b = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

`ifdef MD_MAC_EN
  logic [2*WIDTH-1:0] w_hilo;
  assign w_hilo    = {r_hi, r_lo};
  assign w_mul_res = !r_acc_en ? w_prod
                   : (r_acc_sub ? (w_hilo - w_prod) : (w_hilo + w_prod));
`else
  assign w_mul_res = w_prod;
`endif

  // --------------------------------------------------------------------------
  // Divide datapath
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  assign w_mag_a = (r_signed && r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
  assign w_mag_b = (r_signed && r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  // Top bit of the difference is the borrow: set means "restore".
  assign w_diff  = w_shift - {1'b0, r_dvs};

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_mul_commit = 1'b0;
    w_div_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && w_op_ok) begin
          w_accept    = 1'b1;
          w_state_nxt = w_is_div ? S_DIV_LOAD : S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_mul_commit = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      S_DIV_LOAD: begin
        w_state_nxt = S_DIV_ITER;
      end
      S_DIV_ITER: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DIV_FIX;
        end
      end
      S_DIV_FIX: begin
        w_div_commit = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
`ifdef MD_MAC_EN
      r_acc_en  <= 1'b0;
      r_acc_sub <= 1'b0;
`endif
    end else begin
      r_done <= w_mul_commit | w_div_commit;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_signed <= bus.op[0];
            r_cnt    <= w_is_div ? '0 : c_CW'(MUL_LAT - 1);
`ifdef MD_MAC_EN
            r_acc_en  <= bus.op[2];
            r_acc_sub <= bus.op[1];
`endif
          end else begin
            // mthi/mtlo only land when no operation is being accepted.
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_mul_res;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV_LOAD: begin
          r_quo  <= w_mag_a;
          r_rem  <= '0;
          r_dvs  <= w_mag_b;
          r_qneg <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_rneg <= r_signed & r_a[WIDTH-1];
          r_dz   <= (r_b == '0);
          r_cnt  <= c_CW'(WIDTH - 1);
        end
        S_DIV_ITER: begin
          if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_DIV_FIX: begin
          // Most-negative / -1 needs no special case: the magnitude quotient
          // 2^(WIDTH-1) with a positive sign already reads as most-negative.
          if (r_dz) begin
            r_lo <= '1;
            r_hi <= r_a;
          end else begin
            r_lo <= r_qneg ? (~r_quo + 1'b1) : r_quo;
            r_hi <= r_rneg ? (~r_rem + 1'b1) : r_rem;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/md_unit.md
# md_unit

Parametrised iterative multiply/divide unit with HI/LO accumulator registers, sitting beside the ALU in the execute stage. It accepts one operation per start handshake, holds `busy` for the operation's latency so the decode stage stalls HI/LO consumers, then commits a 2×WIDTH result to HI/LO and pulses `done`. It generalises the fixed-width 32-bit unit in width and multiply latency, replaces the one-shot `/`/`%` with a bit-serial restoring divider, and defines divide-by-zero and signed-overflow results.

## Interface
- `WIDTH`, 32: operand, HI and LO width; even, ≥8.
- `MUL_LAT`, 4: multiply/accumulate busy cycles; 1..16.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only when `busy`=0.
- `op` input 3: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MADDU, 5 MADD, 6 MSUBU, 7 MSUB.
- `a` input WIDTH: rs operand / dividend.
- `b` input WIDTH: rt operand / divisor.
- `hi_we` input 1: write `wdata` to HI (mthi).
- `lo_we` input 1: write `wdata` to LO (mtlo).
- `wdata` input WIDTH: HI/LO write data.
- `busy` output 1: operation in flight.
- `done` output 1: one-cycle pulse on result commit.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States: IDLE, MUL, DIV_LOAD, DIV_ITER, DIV_FIX.
- IDLE + `start` with valid op: latch `a`, `b`, `op` into internal registers; go MUL (ops 0,1,4–7) or DIV_LOAD (ops 2,3). Inputs need not be held after the accept edge.
- MUL: product of latched operands (unsigned for even op codes, two's-complement signed for odd), 2×WIDTH bits. MULT/MULTU: {HI,LO} ← product. MADD(U): {HI,LO} ← {HI,LO} + product. MSUB(U): {HI,LO} ← {HI,LO} − product; mod 2^(2×WIDTH), no overflow flag. HI/LO used are the values at commit.
- Counter loaded with MUL_LAT−1, decrements per cycle; at 0 commit, pulse `done`, return IDLE.
- DIV_LOAD: DIV takes magnitudes, records quotient sign (a^b) and remainder sign (a). One cycle.
- DIV_ITER: exactly WIDTH restoring shift-subtract steps, one quotient bit per cycle, MSB first.
- DIV_FIX: apply signs; LO ← quotient, HI ← remainder (truncating, remainder sign = dividend sign); pulse `done`; return IDLE.
- Divide by zero (`b`=0, DIV or DIVU): LO ← all ones, HI ← `a`; full latency still taken.
- DIV of most-negative by −1: LO ← most-negative, HI ← 0.
- `hi_we`/`lo_we` in IDLE without `start`: write `wdata` next edge; both may be set in one cycle.
- `start` and a write in the same IDLE cycle: `start` wins, write dropped.
- `start`, `hi_we`, `lo_we` while `busy`=1: ignored; no queueing.

## Timing
- Reset values: `busy` 0, `done` 0, `hi` 0, `lo` 0, state IDLE, counter 0.
- Accept edge E0: `busy` 1 after E0.
- Multiply family: HI/LO update and `done` high after edge E0+MUL_LAT; `busy` low after the same edge, so a new `start` is accepted the cycle `done` is high.
- Divide: HI/LO update and `done` high after E0+WIDTH+2 (load + WIDTH iterations + fix); 34 for WIDTH=32.
- `done` high exactly one cycle per accepted op; `busy` and `done` never both 1.
- `hi`/`lo` are plain register outputs; no combinational path from inputs.
- `reset` mid-operation: abort on that edge; all outputs to reset values; no `done`.

## Configuration
- `MD_MAC_EN` defined: ops 4–7 accumulate as above.
- Not defined: ops 4–7 are not accepted: `start` with those codes ignored, `busy` stays 0, HI/LO unchanged, no `done`; accumulator adder/subtractor not built.

## Test plan
- MULT a=0xFFFF_FFFE (−2), b=3, WIDTH=32, MUL_LAT=4 -> after 4 cycles hi=0xFFFF_FFFF, lo=0xFFFF_FFFA, one `done` pulse.
- DIV a=0xFFFF_FFF9 (−7), b=2 -> after 34 cycles lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIVU a=7, b=0 -> lo=0xFFFF_FFFF, hi=7.
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- mthi 0, mtlo 0x10 then MSUBU a=3, b=7 -> {hi,lo}=0xFFFF_FFFF_FFFF_FFFB; with `MD_MAC_EN` undefined -> `busy` stays 0, lo=0x10.
- `start` + `hi_we` same cycle, then `start`/`lo_we` while busy -> write dropped, second op ignored, one `done` only.
- `reset` at cycle 10 of DIV -> next cycle busy=0, hi=lo=0, no `done`; WIDTH=16 MULTU 0xFFFF×0xFFFF -> hi=0xFFFE, lo=0x0001.
